sdram_responder: RTL and testbench
==================================

# sdram_responder

Synthesizable single-data-rate SDRAM device responder: the chip-side end of the SDRAM command interface driven by the team's SDRAM controller. It decodes CS/RAS/CAS/WE commands, tracks the init sequence, mode register, open rows and per-bank timing, stores write data in a small on-chip memory and returns read data after the programmed CAS latency. Protocol violations raise sticky error flags. It is used as the memory model in controller benches and as a loopback target on FPGA builds without an SDRAM fitted.

## Interface
- ROW_WIDTH, 13, row address bits
- COL_WIDTH, 10, column address bits
- BANK_WIDTH, 2, bank address bits
- SDRADDR_WIDTH, max(ROW_WIDTH,COL_WIDTH), address bus width
- MEM_AW, 12, backing memory depth is 2^MEM_AW bytes
- T_RCD, 2, min cycles ACT→READ/WRITE, same bank
- T_RP, 2, min cycles PRE/PALL/auto-precharge→next ACT, same bank
- T_RFC, 7, min cycles REF→any non-NOP command
- clk  in  1  single clock; all commands sampled on rising edge
- rst  in  1  synchronous, active-high reset
- clock_enable  in  1  CKE; low → cycle treated as NOP
- cs_n, ras_n, cas_n, we_n  in  1 each  command strobes
- bank_addr  in  BANK_WIDTH  bank select
- addr  in  SDRADDR_WIDTH  row/column/mode address; addr[10] = auto-precharge / precharge-all
- data_mask  in  1  DQM, sampled with READ/WRITE
- dq_in  in  8  write data from bus
- dq_out  out  8  read data to bus
- dq_oe  out  1  drive enable for dq_out
- init_done  out  1  init sequence complete
- cas_latency  out  3  programmed CL (0 until MRS)
- err  out  6  sticky protocol error flags

## Operation
- Decode (cs_n,ras_n,cas_n,we_n): 1xxx or CKE=0 → NOP; 0111 NOP; 0011 ACT; 0101 READ; 0100 WRITE; 0010 PRE (addr[10]=1 → all banks); 0001 REF; 0000 MRS; 0110 (burst stop) treated as NOP.
- Init FSM: WAIT_PALL → (PRE with addr[10]) → WAIT_REF1 → REF → WAIT_REF2 → REF → WAIT_MRS → MRS → READY. init_done=1 only in READY. NOPs hold state. Any other command before READY: err[0], state unchanged, command otherwise ignored.
- MRS (any state from WAIT_MRS on): addr[6:4] → cas_latency; addr[2:0] must be 0 and addr[6:4] ∈ {2,3}, else err[5] (cas_latency still updated).
- Per bank: open flag, open row register, timer.
- ACT: bank open → err[2]; timer≠0 → err[4]; otherwise open, store row=addr[ROW_WIDTH-1:0]. Timer loaded T_RCD.
- READ/WRITE: bank closed → err[1], no access; timer≠0 → err[3], access still performed. Column = addr[COL_WIDTH-1:0]. Memory index = low MEM_AW bits of {bank, row, column}.
- WRITE: dq_in stored at index unless data_mask=1.
- READ: data_mask=0 → memory word returned with dq_oe=1 after CL; data_mask=1 → no drive.
- addr[10]=1 on READ/WRITE: bank closed after the access, timer loaded T_RP.
- PRE: closes bank (all banks if addr[10]), loads affected timers T_RP; PRE to closed bank legal.
- REF: any bank open → err[2]; loads global timer T_RFC. Any non-NOP while global timer≠0 → err[4].
- err bits only cleared by rst.

## Timing
- Command sampled at edge n; timers loaded T, decrement to 0; command at edge n+T legal, n+T−1 violates.
- Read pipeline: READ at edge n → dq_out/dq_oe valid from edge n+CL for exactly one cycle (burst length 1). Back-to-back READs each cycle give back-to-back data.
- WRITE at edge n then READ same index at n+1 returns new data.
- Reset values: dq_oe=0, dq_out=0, init_done=0, cas_latency=0, err=0, all banks closed, all timers 0, read pipeline flushed, FSM WAIT_PALL. Memory contents not reset.
- rst mid-read: dq_oe=0 from the cycle after the reset edge; pending data dropped.
- READ when CL invalid (0/1/≥4): err[5], no drive.

## Test plan
- Init (PALL, REF, 7 NOP, REF, 7 NOP, MRS addr=0x020) → init_done=1, cas_latency=2, err=0.
- ACT bank1 row5, 2 NOPs, WRITE col 0x3A auto-pre dq_in=0xA5, 2 NOPs, ACT bank1 row5, 2 NOPs, READ col 0x3A → dq_out=0xA5, dq_oe=1 two cycles after READ only; err=0.
- MRS CL=3, repeat read → data one cycle later; MRS addr=0x021 → err[5].
- READ bank2 never activated → err[1], dq_oe stays 0; READ one cycle after ACT (T_RCD=2) → err[3], data still returned.
- ACT before MRS → err[0], bank stays closed; ACT to open bank → err[2]; command 3 cycles after REF → err[4].
- rst asserted one cycle after READ → dq_oe=0 throughout, init_done=0, err=0, cas_latency=0.

Source files
------------

// File: rtl/sdram_responder_if.sv
// Command/data bus between an SDRAM controller (master) and the
// sdram_responder device model (slave). Clock and reset stay plain ports.
interface sdram_responder_if #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 10,
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) ();
    logic                     clock_enable;
    logic                     cs_n;
    logic                     ras_n;
    logic                     cas_n;
    logic                     we_n;
    logic [BANK_WIDTH-1:0]    bank_addr;
    logic [SDRADDR_WIDTH-1:0] addr;
    logic                     data_mask;
    logic [7:0]               dq_in;
    logic [7:0]               dq_out;
    logic                     dq_oe;

    modport master (
        output clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr, data_mask, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr, data_mask, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Chip-side SDR SDRAM responder: decodes commands, follows the init sequence,
// tracks open rows and per-bank timing, stores data in an on-chip byte memory
// and returns read data after the programmed CAS latency. Protocol violations
// set sticky error flags:
//   err[0] command out of init order      err[3] READ/WRITE inside tRCD
//   err[1] READ/WRITE to a closed bank    err[4] command inside tRP/tRFC
//   err[2] ACT to open bank / REF w/ open err[5] bad mode word or READ with bad CL
module sdram_responder #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 10,
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_AW        = 12,
    parameter int T_RCD         = 2,
    parameter int T_RP          = 2,
    parameter int T_RFC         = 7
) (
    input  logic               clk,
    input  logic               rst,
    sdram_responder_if.slave   bus,
    output logic               init_done,
    output logic [2:0]         cas_latency,
    output logic [5:0]         err
);

    localparam int NUM_BANKS = 2 ** BANK_WIDTH;
    localparam int FULL_W    = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    // Timers hold "cycles left minus one": a command T edges after the load
    // sees zero and is legal, one edge earlier it still sees a non-zero count.
    localparam int T_MAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                           : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] LD_RCD = TW'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [TW-1:0] LD_RP  = TW'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [TW-1:0] LD_RFC = TW'((T_RFC > 0) ? T_RFC - 1 : 0);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MRS
    } cmd_t;

    typedef enum logic [2:0] {
        ST_WAIT_PALL, ST_WAIT_REF1, ST_WAIT_REF2, ST_WAIT_MRS, ST_READY
    } init_state_t;

    init_state_t            state;
    cmd_t                   cmd;
    logic                   init_ok;
    logic [NUM_BANKS-1:0]   bank_open;
    logic [ROW_WIDTH-1:0]   open_row   [NUM_BANKS];
    logic [TW-1:0]          bank_timer [NUM_BANKS];
    logic [TW-1:0]          ref_timer;
    logic [3:1]             pipe_v;
    logic [7:0]             pipe_d     [3:1];
    logic [7:0]             mem        [2**MEM_AW];
    logic [FULL_W-1:0]      full_addr;
    logic [MEM_AW-1:0]      mem_idx;
    logic [7:0]             rd_word;
    logic                   mem_we;
    logic                   cl_valid;
    logic                   unused_addr_bits;

    // Decode the strobes; CKE low or CS_N high reads as NOP, burst stop too.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cmd = CMD_NOP;
        if (bus.clock_enable && !bus.cs_n) begin
            unique case ({bus.ras_n, bus.cas_n, bus.we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Which command the init sequence is willing to accept in each state.
    always_comb begin
        init_ok = 1'b0;
        unique case (state)
            ST_WAIT_PALL: init_ok = (cmd == CMD_PRE) && bus.addr[10];
            ST_WAIT_REF1,
            ST_WAIT_REF2: init_ok = (cmd == CMD_REF);
            ST_WAIT_MRS:  init_ok = (cmd == CMD_MRS);
            default:      init_ok = 1'b1;
        endcase
    end

    // Memory index is the low MEM_AW bits of {bank, open row, column}.
    always_comb begin
        full_addr        = {bus.bank_addr, open_row[bus.bank_addr], bus.addr[COL_WIDTH-1:0]};
        mem_idx          = full_addr[MEM_AW-1:0];
        unused_addr_bits = &{1'b0, full_addr[FULL_W-1:MEM_AW]};
        rd_word          = mem[mem_idx];
        cl_valid         = (cas_latency == 3'd2) || (cas_latency == 3'd3);
        mem_we           = !rst && (cmd == CMD_WRITE) && (state == ST_READY)
                           && bank_open[bus.bank_addr] && !bus.data_mask;
    end

    // Backing byte store; written by unmasked WRITEs to an open bank.
    // NOTE: the memory has no reset branch -- contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= bus.dq_in;
    end

    // Init FSM, bank/timer bookkeeping, read pipeline and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WAIT_PALL;
            init_done   <= 1'b0;
            cas_latency <= '0;
            err         <= '0;
            bank_open   <= '0;
            ref_timer   <= '0;
            pipe_v      <= '0;
            bus.dq_oe   <= 1'b0;
            bus.dq_out  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_row[b]   <= '0;
                bank_timer[b] <= '0;
            end
            for (int s = 1; s <= 3; s++) pipe_d[s] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so later loads in this block override the countdown below.
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_timer[b] != '0) bank_timer[b] <= bank_timer[b] - 1'b1;
            end
            if (ref_timer != '0) ref_timer <= ref_timer - 1'b1;

            // Stage k reaches the pins k edges after it is loaded.
            bus.dq_oe  <= pipe_v[1];
            bus.dq_out <= pipe_v[1] ? pipe_d[1] : 8'h00;
            pipe_v     <= {1'b0, pipe_v[3:2]};
            pipe_d[1]  <= pipe_d[2];
            pipe_d[2]  <= pipe_d[3];

            if (cmd != CMD_NOP) begin
                if (ref_timer != '0) err[4] <= 1'b1;

                if (!init_ok) begin
                    err[0] <= 1'b1;
                end else begin
                    unique case (cmd)
                        CMD_ACT: begin
                            if (bank_open[bus.bank_addr]) begin
                                err[2] <= 1'b1;
                            end else if (bank_timer[bus.bank_addr] != '0 || ref_timer != '0) begin
                                err[4] <= 1'b1;
                            end else begin
                                bank_open[bus.bank_addr]  <= 1'b1;
                                open_row[bus.bank_addr]   <= bus.addr[ROW_WIDTH-1:0];
                                bank_timer[bus.bank_addr] <= LD_RCD;
                            end
                        end
                        CMD_READ, CMD_WRITE: begin
                            if (!bank_open[bus.bank_addr]) begin
                                err[1] <= 1'b1;
                            end else begin
                                if (bank_timer[bus.bank_addr] != '0) err[3] <= 1'b1;
                                if (cmd == CMD_READ) begin
                                    if (!cl_valid) begin
                                        err[5] <= 1'b1;
                                    end else if (!bus.data_mask) begin
                                        if (cas_latency == 3'd2) begin
                                            pipe_v[2] <= 1'b1;
                                            pipe_d[2] <= rd_word;
                                        end else begin
                                            pipe_v[3] <= 1'b1;
                                            pipe_d[3] <= rd_word;
                                        end
                                    end
                                end
                                if (bus.addr[10]) begin
                                    bank_open[bus.bank_addr]  <= 1'b0;
                                    bank_timer[bus.bank_addr] <= LD_RP;
                                end
                            end
                        end
                        CMD_PRE: begin
                            if (bus.addr[10]) begin
                                bank_open <= '0;
                                for (int b = 0; b < NUM_BANKS; b++) bank_timer[b] <= LD_RP;
                            end else begin
                                bank_open[bus.bank_addr]  <= 1'b0;
                                bank_timer[bus.bank_addr] <= LD_RP;
                            end
                            if (state == ST_WAIT_PALL) state <= ST_WAIT_REF1;
                        end
                        CMD_REF: begin
                            if (|bank_open) err[2] <= 1'b1;
                            ref_timer <= LD_RFC;
                            if (state == ST_WAIT_REF1) state <= ST_WAIT_REF2;
                            if (state == ST_WAIT_REF2) state <= ST_WAIT_MRS;
                        end
                        CMD_MRS: begin
                            cas_latency <= bus.addr[6:4];
                            if (bus.addr[2:0] != 3'd0 ||
                                (bus.addr[6:4] != 3'd2 && bus.addr[6:4] != 3'd3)) begin
                                err[5] <= 1'b1;
                            end
                            if (state == ST_WAIT_MRS) begin
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, write/read round trips at CL2/CL3,
// timing and ordering violations, data mask, and reset during a pending read.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic       clk;
    logic       rst;
    logic       init_done;
    logic [2:0] cas_latency;
    logic [5:0] err;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;

    sdram_responder_if bus ();

    sdram_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .init_done   (init_done),
        .cas_latency (cas_latency),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command, let one rising edge take it, then sit 1 ns past the edge.
    task automatic tick(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic dm, input logic [7:0] d);
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.bank_addr = ba;
        bus.addr      = a;
        bus.data_mask = dm;
        bus.dq_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) tick(C_NOP, 2'd0, 13'h0, 1'b0, 8'h00);
    endtask

    task automatic do_init();
        tick(C_PRE, 2'd0, 13'h400, 1'b0, 8'h00);
        tick(C_REF, 2'd0, 13'h000, 1'b0, 8'h00);
        nops(7);
        tick(C_REF, 2'd0, 13'h000, 1'b0, 8'h00);
        nops(7);
        tick(C_MRS, 2'd0, 13'h020, 1'b0, 8'h00);
    endtask

    initial begin
        rst              = 1'b1;
        bus.clock_enable = 1'b1;
        tick(C_NOP, 2'd0, 13'h0, 1'b0, 8'h00);
        tick(C_NOP, 2'd0, 13'h0, 1'b0, 8'h00);
        rst = 1'b0;

        // Reset state
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_cl", 32'(cas_latency), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_dq_oe", 32'(bus.dq_oe), 32'h0);
        check("rst_dq_out", 32'(bus.dq_out), 32'h0);

        // Clean init, CL=2
        do_init();
        check("init_done", 32'(init_done), 32'h1);
        check("init_cl", 32'(cas_latency), 32'h2);
        check("init_err", 32'(err), 32'h0);

        // Write with auto-precharge, reopen, read back at CL2
        tick(C_ACT, 2'd1, 13'h005, 1'b0, 8'h00);
        nops(2);
        tick(C_WR, 2'd1, 13'h43A, 1'b0, 8'hA5);
        nops(2);
        tick(C_ACT, 2'd1, 13'h005, 1'b0, 8'h00);
        nops(2);
        tick(C_RD, 2'd1, 13'h03A, 1'b0, 8'h00);
        check("cl2_oe_e1", 32'(bus.dq_oe), 32'h0);
        nops(1);
        check("cl2_oe_e2", 32'(bus.dq_oe), 32'h0);
        nops(1);
        check("cl2_oe_e3", 32'(bus.dq_oe), 32'h1);
        check("cl2_data", 32'(bus.dq_out), 32'hA5);
        nops(1);
        check("cl2_oe_after", 32'(bus.dq_oe), 32'h0);
        check("rw_err", 32'(err), 32'h0);

        // CL=3 read of the same word, then an illegal mode word
        tick(C_MRS, 2'd0, 13'h030, 1'b0, 8'h00);
        check("mrs_cl3", 32'(cas_latency), 32'h3);
        tick(C_RD, 2'd1, 13'h03A, 1'b0, 8'h00);
        nops(2);
        check("cl3_oe_early", 32'(bus.dq_oe), 32'h0);
        nops(1);
        check("cl3_oe", 32'(bus.dq_oe), 32'h1);
        check("cl3_data", 32'(bus.dq_out), 32'hA5);
        nops(1);
        check("cl3_oe_after", 32'(bus.dq_oe), 32'h0);
        tick(C_MRS, 2'd0, 13'h021, 1'b0, 8'h00);
        check("mrs_bad_err", 32'(err), 32'h20);
        check("mrs_bad_cl", 32'(cas_latency), 32'h2);

        // READ to a never-activated bank
        tick(C_RD, 2'd2, 13'h010, 1'b0, 8'h00);
        check("closed_err", 32'(err), 32'h22);
        nops(2);
        check("closed_no_oe", 32'(bus.dq_oe), 32'h0);

        // READ one cycle after ACT: tRCD error, data still returned
        tick(C_ACT, 2'd2, 13'h003, 1'b0, 8'h00);
        nops(2);
        tick(C_WR, 2'd2, 13'h015, 1'b0, 8'h5C);
        tick(C_PRE, 2'd2, 13'h000, 1'b0, 8'h00);
        nops(2);
        tick(C_ACT, 2'd2, 13'h003, 1'b0, 8'h00);
        tick(C_RD, 2'd2, 13'h015, 1'b0, 8'h00);
        check("trcd_err", 32'(err), 32'h2A);
        nops(1);
        check("trcd_oe_e1", 32'(bus.dq_oe), 32'h0);
        nops(1);
        check("trcd_oe", 32'(bus.dq_oe), 32'h1);
        check("trcd_data", 32'(bus.dq_out), 32'h5C);

        // WRITE then READ the next cycle returns the new byte
        tick(C_WR, 2'd2, 13'h015, 1'b0, 8'h77);
        tick(C_RD, 2'd2, 13'h015, 1'b0, 8'h00);
        nops(2);
        check("wr_rd_data", 32'(bus.dq_out), 32'h77);

        // Masked write ignored; back-to-back reads; masked read not driven
        tick(C_WR, 2'd2, 13'h015, 1'b1, 8'h11);
        tick(C_WR, 2'd2, 13'h016, 1'b0, 8'h88);
        tick(C_RD, 2'd2, 13'h015, 1'b0, 8'h00);
        tick(C_RD, 2'd2, 13'h016, 1'b0, 8'h00);
        tick(C_RD, 2'd2, 13'h015, 1'b1, 8'h00);
        check("b2b_first_oe", 32'(bus.dq_oe), 32'h1);
        check("b2b_first", 32'(bus.dq_out), 32'h77);
        nops(1);
        check("b2b_second_oe", 32'(bus.dq_oe), 32'h1);
        check("b2b_second", 32'(bus.dq_out), 32'h88);
        nops(1);
        check("dm_read_oe", 32'(bus.dq_oe), 32'h0);
        check("b2b_err", 32'(err), 32'h2A);

        // ACT to an open bank, then a command inside tRFC
        tick(C_ACT, 2'd2, 13'h003, 1'b0, 8'h00);
        check("act_open_err", 32'(err), 32'h2E);
        tick(C_PRE, 2'd0, 13'h400, 1'b0, 8'h00);
        nops(2);
        tick(C_REF, 2'd0, 13'h000, 1'b0, 8'h00);
        check("ref_ok_err", 32'(err), 32'h2E);
        nops(2);
        tick(C_PRE, 2'd0, 13'h000, 1'b0, 8'h00);
        check("trfc_err", 32'(err), 32'h3E);
        nops(7);

        // Reset one cycle after a READ drops the pending data
        tick(C_ACT, 2'd2, 13'h003, 1'b0, 8'h00);
        nops(2);
        tick(C_RD, 2'd2, 13'h015, 1'b0, 8'h00);
        rst = 1'b1;
        tick(C_NOP, 2'd0, 13'h0, 1'b0, 8'h00);
        check("rst_rd_oe1", 32'(bus.dq_oe), 32'h0);
        tick(C_NOP, 2'd0, 13'h0, 1'b0, 8'h00);
        check("rst_rd_oe2", 32'(bus.dq_oe), 32'h0);
        check("rst_rd_init", 32'(init_done), 32'h0);
        check("rst_rd_err", 32'(err), 32'h0);
        check("rst_rd_cl", 32'(cas_latency), 32'h0);
        rst = 1'b0;
        nops(1);
        check("rst_rd_oe3", 32'(bus.dq_oe), 32'h0);

        // ACT before init completes is rejected and leaves the bank closed
        tick(C_ACT, 2'd1, 13'h005, 1'b0, 8'h00);
        check("early_act_err", 32'(err), 32'h01);
        check("early_act_init", 32'(init_done), 32'h0);
        do_init();
        check("reinit_done", 32'(init_done), 32'h1);
        tick(C_ACT, 2'd1, 13'h005, 1'b0, 8'h00);
        check("reopen_err", 32'(err), 32'h01);

        // Memory contents survive reset
        nops(2);
        tick(C_RD, 2'd1, 13'h03A, 1'b0, 8'h00);
        nops(2);
        check("persist_oe", 32'(bus.dq_oe), 32'h1);
        check("persist_data", 32'(bus.dq_out), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
